audio_avg_filter: RTL and testbench
===================================

# audio_avg_filter

Parametrised moving-average noise filter for the DE1-SoC audio path. It sits between the `audio_codec` read and write ports in place of the plain pass-through. For each stereo sample it drives the codec `read`/`write` handshake itself, averages the last 2^LOG2_DEPTH samples per channel, and returns the result to the DAC.

## Interface
- `DATA_W`, default 24: sample width, signed two's complement.
- `LOG2_DEPTH`, default 3: averaging window is 2^LOG2_DEPTH samples per channel; legal range 1..5.
- `CLOCK_50`, input, 1: system clock, same clock as `audio_codec`.
- `reset_n`, input, 1: one clock; reset is asynchronous and active-low.
- `read_ready`, input, 1: codec ADC FIFO has a sample pair.
- `write_ready`, input, 1: codec DAC FIFO has space.
- `readdata_left`, input, DATA_W: ADC left sample.
- `readdata_right`, input, DATA_W: ADC right sample.
- `read`, output, 1: one-cycle pop strobe to the codec.
- `write`, output, 1: one-cycle push strobe to the codec.
- `writedata_left`, output, DATA_W: filtered left sample.
- `writedata_right`, output, DATA_W: filtered right sample.
- `bypass`, input, 1: present only with `AUDIO_FILTER_BYPASS_EN`; see Configuration.

## Operation
- The FSM has five states: S_IDLE, S_ACC, S_OUT, S_WAIT, S_DONE.
- **S_IDLE:** when `read_ready`=1, latch both `readdata_*` into `in_l`/`in_r`, register `read`<=1, go to S_ACC. Otherwise hold.
- **S_ACC:** `read`<=0.
  - Per channel: `sum <= sum + in - hist[ptr]`, then `hist[ptr] <= in`.
  - `ptr <= ptr + 1`, modulo 2^LOG2_DEPTH; wraps from 2^LOG2_DEPTH-1 to 0.
  - Go to S_OUT.
- **S_OUT:** `writedata_* <= sum >>> LOG2_DEPTH` (arithmetic shift, truncation toward -inf). Go to S_WAIT.
- **S_WAIT:** if `write_ready`=1, `write`<=1 and go to S_DONE; otherwise hold indefinitely. No read is issued while waiting.
- **S_DONE:** `write`<=0, go to S_IDLE.
- **Widths:**
  - Accumulators are signed DATA_W+LOG2_DEPTH bits, so they never overflow.
  - History is 2·2^LOG2_DEPTH registers of DATA_W bits.
  - Output is the low DATA_W bits of the shifted sum, which always fits.
- **Warm-up:** history resets to zero, so the first 2^LOG2_DEPTH outputs ramp toward the true average. This is intentional.
- **Reset, asynchronous (including mid-operation):**
  - State returns to S_IDLE.
  - `read`, `write` = 0.
  - `writedata_*` = 0.
  - All history, sums and `ptr` = 0.
  - Any in-flight sample is discarded and no partial `write` is issued.
- Both channels share one FSM and one `ptr`; they are always processed in lock-step.

## Timing
- `read` is high exactly 1 cycle, one cycle after the latching edge. It is never high in two consecutive cycles.
- `write` is high exactly 1 cycle. `writedata_*` is stable from S_OUT until the next S_OUT, so it is valid while `write`=1.
- Latency from the read-latch edge to `write` high is 3 cycles when `write_ready` is already 1.
- Minimum sample period is 5 cycles, far below the 48 kHz frame rate (about 1042 cycles at 50 MHz).
- `read_ready` and `write_ready` are ignored outside S_IDLE and S_WAIT respectively. Simultaneous assertion of both needs no arbitration.

## Configuration
- **Macro `AUDIO_FILTER_BYPASS_EN` defined:** adds the `bypass` port.
  - When `bypass`=1 in S_OUT, `writedata_*` <= `in_*` (raw samples).
  - History and sums still update, so switching back is glitch-free with a full window.
  - `bypass` is sampled only in S_OUT.
- **Macro undefined:** no port; the filter is always active.

## Test plan
All scenarios use `DATA_W`=24 and `LOG2_DEPTH`=2.
- **Step response:** feed constant left = right = 0x000400 for 6 samples -> outputs 0x000100, 0x000200, 0x000300, 0x000400, 0x000400, 0x000400.
- **Negative / rounding:** from reset, feed left 0xFFFC01 (-1023), right 0x000003 -> first left out 0xFFFF00 (-256, floor), first right out 0x000000.
- **Wrap and saturation range:** feed 0x7FFFFF ×4, then 0x800000 ×4.
  - After the 4th sample, out = 0x7FFFFF.
  - After the 8th, out = 0x800000, with no overflow and `ptr` wrapped twice.
- **Backpressure:** hold `write_ready`=0 for 100 cycles with `read_ready`=1 -> exactly one `read` pulse, `write` stays 0, FSM in S_WAIT. Release -> one `write` pulse 1 cycle later.
- **Reset mid-operation:** assert `reset_n`=0 in S_ACC -> `read`/`write`/`writedata_*` = 0 immediately. The next sample of 0x000400 outputs 0x000100.
- **Bypass (`AUDIO_FILTER_BYPASS_EN`):** with `bypass`=1, feed 0x000400 -> out 0x000400. Drop to `bypass`=0 on the 5th sample -> out 0x000400, since the history is already full.

Source files
------------

// File: rtl/audio_avg_filter.sv
// Moving-average filter between the codec ADC and DAC FIFOs; optional raw-sample bypass via AUDIO_FILTER_BYPASS_EN.
// Write strobe 3 cycles after the read-latch edge; holds in S_WAIT while the DAC FIFO is full and issues no reads.
module audio_avg_filter #(
   parameter int DATA_W     = 24,
   parameter int LOG2_DEPTH = 3
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
`ifdef AUDIO_FILTER_BYPASS_EN
   input  logic              bypass,
`endif
   input  logic              read_ready,
   input  logic              write_ready,
   input  logic [DATA_W-1:0] readdata_left,
   input  logic [DATA_W-1:0] readdata_right,
   output logic              read,
   output logic              write,
   output logic [DATA_W-1:0] writedata_left,
   output logic [DATA_W-1:0] writedata_right
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SW    = DATA_W + LOG2_DEPTH;

   typedef enum logic [2:0] {S_IDLE, S_ACC, S_OUT, S_WAIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic                  read_q, read_d;
   logic                  write_q, write_d;
   logic [DATA_W-1:0]     in_q [2];
   logic [DATA_W-1:0]     in_d [2];
   logic [DATA_W-1:0]     wd_q [2];
   logic [DATA_W-1:0]     wd_d [2];
   logic signed [SW-1:0]  sum_q [2];
   logic signed [SW-1:0]  sum_d [2];
   logic [DATA_W-1:0]     hist_q [2][DEPTH];
   logic [DATA_W-1:0]     hist_d [2][DEPTH];
   logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0]     rd_dat [2];

   function automatic logic [SW-1:0] sext(input logic [DATA_W-1:0] x);
      return {{LOG2_DEPTH{x[DATA_W-1]}}, x};
   endfunction

   assign rd_dat[0] = readdata_left;
   assign rd_dat[1] = readdata_right;

   always_comb begin
      state_d = state_q;
      read_d  = 1'b0;
      write_d = 1'b0;
      in_d    = in_q;
      wd_d    = wd_q;
      sum_d   = sum_q;
      hist_d  = hist_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (read_ready) begin
               in_d    = rd_dat;
               read_d  = 1'b1;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            // Running sum: add the newest sample, drop the one it replaces in the window.
            for (int c = 0; c < 2; c++) begin
               sum_d[c]         = sum_q[c] + sext(in_q[c]) - sext(hist_q[c][ptr_q]);
               hist_d[c][ptr_q] = in_q[c];
            end
            ptr_d   = ptr_q + LOG2_DEPTH'(1);
            state_d = S_OUT;
         end
         S_OUT: begin
            for (int c = 0; c < 2; c++) begin
               wd_d[c] = DATA_W'(sum_q[c] >>> LOG2_DEPTH);
            end
`ifdef AUDIO_FILTER_BYPASS_EN
            if (bypass) begin
               wd_d = in_q;
            end
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (write_ready) begin
               write_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         in_q    <= '{default: '0};
         wd_q    <= '{default: '0};
         sum_q   <= '{default: '0};
         hist_q  <= '{default: '{default: '0}};
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         read_q  <= read_d;
         write_q <= write_d;
         in_q    <= in_d;
         wd_q    <= wd_d;
         sum_q   <= sum_d;
         hist_q  <= hist_d;
         ptr_q   <= ptr_d;
      end
   end

   assign read            = read_q;
   assign write           = write_q;
   assign writedata_left  = wd_q[0];
   assign writedata_right = wd_q[1];

endmodule

// File: tb/tb_audio_avg_filter.sv
// Directed-vector bench for audio_avg_filter with DATA_W=24, LOG2_DEPTH=2.
module tb_audio_avg_filter;
   localparam int DW = 24;
   localparam int LD = 2;
   localparam logic [DW-1:0] STEP_EXP [6] = '{24'h000100, 24'h000200, 24'h000300,
                                              24'h000400, 24'h000400, 24'h000400};

   logic          clk = 1'b0;
   logic          reset_n;
   logic          read_ready, write_ready;
   logic [DW-1:0] rdl, rdr, wdl, wdr;
   logic          rd, wr;
`ifdef AUDIO_FILTER_BYPASS_EN
   logic          bypass;
`endif
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   audio_avg_filter #(.DATA_W(DW), .LOG2_DEPTH(LD)) dut (
      .CLOCK_50        (clk),
      .reset_n         (reset_n),
`ifdef AUDIO_FILTER_BYPASS_EN
      .bypass          (bypass),
`endif
      .read_ready      (read_ready),
      .write_ready     (write_ready),
      .readdata_left   (rdl),
      .readdata_right  (rdr),
      .read            (rd),
      .write           (wr),
      .writedata_left  (wdl),
      .writedata_right (wdr)
   );

   task automatic apply_reset();
      reset_n     = 1'b0;
      read_ready  = 1'b0;
      write_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Pushes one sample pair through the codec handshake; to=1 if a strobe never came.
   task automatic do_sample(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            output logic [DW-1:0] ol, output logic [DW-1:0] orr,
                            output int lat, output bit to);
      int n;
      to          = 1'b0;
      rdl         = l;
      rdr         = r;
      read_ready  = 1'b1;
      write_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!rd && n < 20) begin @(negedge clk); n++; end
      read_ready = 1'b0;
      if (!rd) to = 1'b1;
      lat = 0;
      while (!wr && lat < 20) begin @(negedge clk); lat++; end
      if (!wr) to = 1'b1;
      ol  = wdl;
      orr = wdr;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int nr;
      apply_reset();
      checks++;
      if (rd !== 1'b0 || wr !== 1'b0) begin
         errors++; $display("FAIL reset_strobes: got read=%b write=%b expected 0 0", rd, wr);
      end
      checks++;
      if (wdl !== 24'h0 || wdr !== 24'h0) begin
         errors++; $display("FAIL reset_data: got %h/%h expected 000000/000000", wdl, wdr);
      end
      nr = 0;
      repeat (8) begin @(negedge clk); if (rd || wr) nr++; end
      checks++;
      if (nr !== 0) begin
         errors++; $display("FAIL idle_quiet: got %0d strobes expected 0", nr);
      end
   endtask

   task automatic test_latency();
      logic [DW-1:0] ol, orr; int lat; bit to;
      apply_reset();
      do_sample(24'h000400, 24'h000800, ol, orr, lat, to);
      checks++;
      if (to || lat !== 3) begin
         errors++; $display("FAIL latency: got %0d (timeout=%0d) expected 3", lat, to);
      end
      checks++;
      if (ol !== 24'h000100 || orr !== 24'h000200) begin
         errors++; $display("FAIL channels: got %h/%h expected 000100/000200", ol, orr);
      end
   endtask

   task automatic test_step();
      logic [DW-1:0] ol, orr; int lat; bit to;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         do_sample(24'h000400, 24'h000400, ol, orr, lat, to);
         checks++;
         if (to || ol !== STEP_EXP[i] || orr !== STEP_EXP[i]) begin
            errors++;
            $display("FAIL step[%0d]: got %h/%h (timeout=%0d) expected %h", i, ol, orr, to, STEP_EXP[i]);
         end
      end
   endtask

   task automatic test_negative();
      logic [DW-1:0] ol, orr; int lat; bit to;
      apply_reset();
      do_sample(24'hFFFC01, 24'h000003, ol, orr, lat, to);
      checks++;
      if (to || ol !== 24'hFFFF00) begin
         errors++; $display("FAIL neg_left: got %h expected FFFF00", ol);
      end
      checks++;
      if (to || orr !== 24'h000000) begin
         errors++; $display("FAIL neg_right: got %h expected 000000", orr);
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] ol, orr; int lat; bit to;
      logic [DW-1:0] got [8];
      bit anyto;
      anyto = 1'b0;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         if (i < 4) do_sample(24'h7FFFFF, 24'h7FFFFF, ol, orr, lat, to);
         else       do_sample(24'h800000, 24'h800000, ol, orr, lat, to);
         got[i] = ol;
         anyto  = anyto | to | (ol !== orr);
      end
      checks++;
      if (anyto) begin
         errors++; $display("FAIL wrap_handshake: got timeout/channel skew=1 expected 0");
      end
      checks++;
      if (got[0] !== 24'h1FFFFF) begin
         errors++; $display("FAIL wrap_first: got %h expected 1FFFFF", got[0]);
      end
      checks++;
      if (got[3] !== 24'h7FFFFF) begin
         errors++; $display("FAIL wrap_max: got %h expected 7FFFFF", got[3]);
      end
      checks++;
      if (got[4] !== 24'h3FFFFF) begin
         errors++; $display("FAIL wrap_mix: got %h expected 3FFFFF", got[4]);
      end
      checks++;
      if (got[7] !== 24'h800000) begin
         errors++; $display("FAIL wrap_min: got %h expected 800000", got[7]);
      end
   endtask

   task automatic test_backpressure();
      int nr, nw;
      apply_reset();
      rdl = 24'h000400; rdr = 24'h000400;
      write_ready = 1'b0;
      read_ready  = 1'b1;
      nr = 0; nw = 0;
      repeat (100) begin @(negedge clk); if (rd) nr++; if (wr) nw++; end
      checks++;
      if (nr !== 1 || nw !== 0) begin
         errors++; $display("FAIL bp_hold: got reads=%0d writes=%0d expected 1 0", nr, nw);
      end
      write_ready = 1'b1;
      read_ready  = 1'b0;
      @(negedge clk);
      checks++;
      if (wr !== 1'b1 || wdl !== 24'h000100) begin
         errors++; $display("FAIL bp_release: got write=%b data=%h expected 1 000100", wr, wdl);
      end
      @(negedge clk);
      checks++;
      if (wr !== 1'b0) begin
         errors++; $display("FAIL bp_single: got write=%b expected 0", wr);
      end
   endtask

   task automatic test_reset_midop();
      logic [DW-1:0] ol, orr; int lat, n; bit to;
      apply_reset();
      do_sample(24'h000400, 24'h000400, ol, orr, lat, to);
      do_sample(24'h000400, 24'h000400, ol, orr, lat, to);
      rdl = 24'h000400; rdr = 24'h000400;
      read_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!rd && n < 20) begin @(negedge clk); n++; end
      reset_n    = 1'b0;
      read_ready = 1'b0;
      #1;
      checks++;
      if (rd !== 1'b0 || wr !== 1'b0 || wdl !== 24'h0 || wdr !== 24'h0) begin
         errors++;
         $display("FAIL midop_reset: got read=%b write=%b data=%h/%h expected 0 0 000000/000000", rd, wr, wdl, wdr);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_sample(24'h000400, 24'h000400, ol, orr, lat, to);
      checks++;
      if (to || ol !== 24'h000100 || orr !== 24'h000100) begin
         errors++; $display("FAIL midop_after: got %h/%h expected 000100", ol, orr);
      end
   endtask

`ifdef AUDIO_FILTER_BYPASS_EN
   task automatic test_bypass();
      logic [DW-1:0] ol, orr; int lat; bit to;
      apply_reset();
      bypass = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_sample(24'h000400, 24'h000400, ol, orr, lat, to);
         checks++;
         if (to || ol !== 24'h000400 || orr !== 24'h000400) begin
            errors++; $display("FAIL bypass_on[%0d]: got %h/%h expected 000400", i, ol, orr);
         end
      end
      bypass = 1'b0;
      do_sample(24'h000400, 24'h000400, ol, orr, lat, to);
      checks++;
      if (to || ol !== 24'h000400 || orr !== 24'h000400) begin
         errors++; $display("FAIL bypass_off: got %h/%h expected 000400", ol, orr);
      end
   endtask
`endif

   initial begin
      reset_n     = 1'b0;
      read_ready  = 1'b0;
      write_ready = 1'b0;
      rdl         = '0;
      rdr         = '0;
`ifdef AUDIO_FILTER_BYPASS_EN
      bypass      = 1'b0;
`endif
      test_reset();
      test_latency();
      test_step();
      test_negative();
      test_wrap();
      test_backpressure();
      test_reset_midop();
`ifdef AUDIO_FILTER_BYPASS_EN
      test_bypass();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500000 expected finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
